wptr_full_lvl: RTL

Write-domain pointer and status generator for the parametrised async FIFO used on the FIR sample path. It advances the binary and Gray write pointers and produces a registered full flag. It adds capabilities the current write-pointer block lacks: Gray-to-binary decode of the synchronised read pointer, a registered fill level, a runtime almost-full threshold, and an overflow indication. It sits beside the write-side memory port and the 2-flop read-pointer synchroniser, and drives the read-domain synchroniser with wptr.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/wptr_full_lvl_if.sv | 25 ++
 rtl/fifo_gray2bin.sv | 14 +
 rtl/wptr_full_lvl.sv | 81 ++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and sizing constants.
// Conversion functions work on a fixed maximum width; narrower pointers are zero-extended.
package fifo_pkg;

  localparam int FIFO_SYNC_STAGES = 2;
  localparam int PTR_MAX = 13;  // ADDR_SIZE up to 12, plus wrap bit

  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Leading zeros of a zero-extended Gray code decode to zeros, so one width serves all.
  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
    logic [PTR_MAX-1:0] b;
    b[PTR_MAX-1] = g[PTR_MAX-1];
    for (int i = PTR_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_lvl_if.sv
// Write-side bus of the async FIFO pointer block: request, synchronised read pointer,
// threshold and overflow clear in; address, Gray pointer, status and enable out.
interface wptr_full_lvl_if #(parameter int ADDR_SIZE = 6);
  logic                  winc;
  logic [ADDR_SIZE:0]    wq2_rptr;
  logic [ADDR_SIZE:0]    afull_thresh;
  logic                  wovf_clr;
  logic [ADDR_SIZE-1:0]  waddr;
  logic [ADDR_SIZE:0]    wptr;
  logic                  wfull;
  logic                  wafull;
  logic [ADDR_SIZE:0]    wlevel;
  logic                  wovf;
  logic                  wen;

  modport master (
    output winc, wq2_rptr, afull_thresh, wovf_clr,
    input  waddr, wptr, wfull, wafull, wlevel, wovf, wen
  );

  modport slave (
    input  winc, wq2_rptr, afull_thresh, wovf_clr,
    output waddr, wptr, wfull, wafull, wlevel, wovf, wen
  );
endinterface

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary decode of a synchronised FIFO pointer, zero latency.
// Shared by the write-side and read-side pointer blocks.
module fifo_gray2bin
  import fifo_pkg::*;
#(
  parameter int W = 7
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  assign bin = W'(gray2bin(PTR_MAX'(gray)));

endmodule

// File: rtl/wptr_full_lvl.sv
// Write pointer, full/almost-full, fill level and overflow for the async FIFO; status registered.
// Build option WOVF_STICKY_EN makes wovf sticky until wovf_clr; otherwise it pulses per dropped write.
module wptr_full_lvl
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE   = 6,
  parameter int AFULL_RESET = 2**ADDR_SIZE - 4
) (
  input  logic wclk,
  input  logic wrst,
  wptr_full_lvl_if.slave bus
);

  localparam int PTR_W = ADDR_SIZE + 1;
  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] DEPTH_V = PTR_W'(DEPTH);

  logic [ADDR_SIZE:0] wbin;
  logic [ADDR_SIZE:0] wbin_next;
  logic [ADDR_SIZE:0] wgray_next;
  logic [ADDR_SIZE:0] rbin;
  logic [ADDR_SIZE:0] lvl_next;
  logic               full_next;
  logic               wen;

  fifo_gray2bin #(.W(PTR_W)) u_rdec (
    .gray (bus.wq2_rptr),
    .bin  (rbin)
  );

  assign wen        = bus.winc & ~bus.wfull;
  assign wbin_next  = wbin + {{ADDR_SIZE{1'b0}}, wen};
  assign wgray_next = PTR_W'(bin2gray(PTR_MAX'(wbin_next)));
  assign lvl_next   = wbin_next - rbin;
  assign full_next  = (wgray_next == {~bus.wq2_rptr[ADDR_SIZE:ADDR_SIZE-1],
                                      bus.wq2_rptr[ADDR_SIZE-2:0]});

  assign bus.wen   = wen;
  assign bus.waddr = wbin[ADDR_SIZE-1:0];

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin       <= '0;
      bus.wptr   <= '0;
      bus.wlevel <= '0;
      bus.wfull  <= 1'b0;
      bus.wafull <= 1'b0;
      bus.wovf   <= 1'b0;
    end else begin
      wbin       <= wbin_next;
      bus.wptr   <= wgray_next;
      bus.wlevel <= lvl_next;
      bus.wfull  <= full_next;
      bus.wafull <= (lvl_next >= bus.afull_thresh);
`ifdef WOVF_STICKY_EN
      // Set takes priority over clear so a drop in the clear cycle is not lost.
      if (bus.winc && bus.wfull)
        bus.wovf <= 1'b1;
      else if (bus.wovf_clr)
        bus.wovf <= 1'b0;
`else
      bus.wovf <= bus.winc & bus.wfull;
`endif
    end
  end

`ifndef WOVF_STICKY_EN
  logic unused_clr;
  assign unused_clr = bus.wovf_clr;
`endif

  a_param_legal: assert property (@(posedge wclk)
    (ADDR_SIZE >= 2) && (ADDR_SIZE <= 12) && (AFULL_RESET <= DEPTH));

  a_full_matches_level: assert property (@(posedge wclk) disable iff (wrst)
    full_next == (lvl_next == DEPTH_V));

  a_thresh_range: assert property (@(posedge wclk) disable iff (wrst)
    bus.afull_thresh <= DEPTH_V);

endmodule
